// File: rtl/add_serial_sched.sv
// Round-robin front end that time-shares one bit-serial adder among NREQ requesters.
// Operands are latched at grant; the sum returns with a one-cycle ack after a fixed latency.
module add_serial_sched #(
   parameter int NREQ    = 4,
   parameter int WIDTH   = 8,
   parameter int LATENCY = 10,
   parameter int IDW     = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic [NREQ-1:0]       ack,
   output logic [WIDTH-1:0]      res_data,
   output logic [IDW-1:0]        res_id,
   output logic                  busy,
   output logic                  add_en,
   output logic [WIDTH-1:0]      add_a,
   output logic [WIDTH-1:0]      add_b,
   input  logic [WIDTH-1:0]      add_out
);

   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;
   localparam logic [1:0] S_RESP  = 2'd3;

   logic [1:0]       state_reg, state_next;
   logic [IDW-1:0]   gnt_reg, last_reg, res_id_reg;
   logic [CW-1:0]    cnt_reg;
   logic [WIDTH-1:0] add_a_reg, add_b_reg, res_data_reg;
   logic [WIDTH-1:0] op_a [NREQ];
   logic [WIDTH-1:0] op_b [NREQ];
   logic [IDW-1:0]   pick_id, scan_idx;
   logic             pick_valid;
   logic             cnt_done;

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
         assign op_a[gi] = req_a[gi*WIDTH +: WIDTH];
         assign op_b[gi] = req_b[gi*WIDTH +: WIDTH];
         assign ack[gi]  = (state_reg == S_RESP) && (gnt_reg == IDW'(gi));
      end
   endgenerate

   // Scan downward so the closest set bit after last_reg is the final assignment.
   always_comb begin
      pick_valid = 1'b0;
      pick_id    = '0;
      scan_idx   = '0;
      for (int k = NREQ; k >= 1; k--) begin
         scan_idx = IDW'((int'(last_reg) + k) % NREQ);
         if (req[scan_idx]) begin
            pick_valid = 1'b1;
            pick_id    = scan_idx;
         end
      end
   end

   assign cnt_done = (cnt_reg == CW'(LATENCY - 1));

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE:  if (pick_valid) state_next = S_ISSUE;
         S_ISSUE: state_next = S_WAIT;
         S_WAIT:  if (cnt_done) state_next = S_RESP;
         S_RESP:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= S_IDLE;
         gnt_reg      <= '0;
         last_reg     <= IDW'(NREQ - 1);
         cnt_reg      <= '0;
         add_a_reg    <= '0;
         add_b_reg    <= '0;
         res_data_reg <= '0;
         res_id_reg   <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            S_IDLE: begin
               if (pick_valid) begin
                  gnt_reg   <= pick_id;
                  add_a_reg <= op_a[pick_id];
                  add_b_reg <= op_b[pick_id];
               end
            end
            S_ISSUE: cnt_reg <= '0;
            S_WAIT: begin
               if (cnt_done) begin
                  res_data_reg <= add_out;
                  res_id_reg   <= gnt_reg;
               end else begin
                  cnt_reg <= cnt_reg + CW'(1);
               end
            end
            S_RESP:  last_reg <= gnt_reg;
            default: ;
         endcase
      end
   end

   assign busy     = (state_reg != S_IDLE);
   assign add_en   = (state_reg == S_ISSUE);
   assign add_a    = add_a_reg;
   assign add_b    = add_b_reg;
   assign res_data = res_data_reg;
   assign res_id   = res_id_reg;

endmodule

// File: tb/tb_add_serial_sched.sv
// Self-checking bench for add_serial_sched: directed vector table, corner sequences,
// and randomized traffic against a transaction-level round-robin model.
module tb_add_serial_sched;

   localparam int NREQ    = 4;
   localparam int WIDTH   = 8;
   localparam int LATENCY = 10;
   localparam int IDW     = 2;

   logic                  clk = 1'b0;
   logic                  rst = 1'b0;
   logic [NREQ-1:0]       req = '0;
   logic [NREQ*WIDTH-1:0] req_a = '0;
   logic [NREQ*WIDTH-1:0] req_b = '0;
   logic [NREQ-1:0]       ack;
   logic [WIDTH-1:0]      res_data;
   logic [IDW-1:0]        res_id;
   logic                  busy;
   logic                  add_en;
   logic [WIDTH-1:0]      add_a;
   logic [WIDTH-1:0]      add_b;
   logic [WIDTH-1:0]      add_out;

   int n_checks = 0;
   int n_fail   = 0;

   add_serial_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .LATENCY(LATENCY), .IDW(IDW)) dut (
      .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
      .ack(ack), .res_data(res_data), .res_id(res_id), .busy(busy),
      .add_en(add_en), .add_a(add_a), .add_b(add_b), .add_out(add_out)
   );

   always #5 clk = ~clk;

   // Adder stand-in: output is only correct LATENCY cycles after the start cycle.
   int adder_cnt;
   always @(posedge clk or negedge rst) begin
      if (!rst) adder_cnt <= 0;
      else if (add_en) adder_cnt <= 1;
      else if (adder_cnt > 0 && adder_cnt < LATENCY) adder_cnt <= adder_cnt + 1;
   end
   always_comb begin
      add_out = WIDTH'(add_a + add_b);
      if (adder_cnt < LATENCY) add_out = add_out ^ 8'hA5;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0d required %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic new_ops(input int i);
      req_a[i*WIDTH +: WIDTH] = WIDTH'($urandom);
      req_b[i*WIDTH +: WIDTH] = WIDTH'($urandom);
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_ack"}, ack, 0);
      check({tag, "_res_data"}, res_data, 0);
      check({tag, "_res_id"}, res_id, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_add_en"}, add_en, 0);
      check({tag, "_add_a"}, add_a, 0);
      check({tag, "_add_b"}, add_b, 0);
   endtask

   task automatic do_reset();
      req = '0;
      rst = 1'b0;
      #1;
      check_quiet("reset");
      tick();
      tick();
      rst = 1'b1;
   endtask

   // One request from idle; cycle c is the c-th cycle after the edge that samples req.
   task automatic single_op(input string tag, input int id, input logic [WIDTH-1:0] a,
                            input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp_sum);
      logic [NREQ-1:0] oh;
      oh = NREQ'(1) << id;
      for (int i = 0; i < NREQ; i++) new_ops(i);
      req_a[id*WIDTH +: WIDTH] = a;
      req_b[id*WIDTH +: WIDTH] = b;
      req = oh;
      for (int c = 1; c <= 13; c++) begin
         tick();
         check($sformatf("%s_add_en_c%0d", tag, c), add_en, (c == 1));
         check($sformatf("%s_ack_c%0d", tag, c), ack, (c == 12) ? oh : '0);
         check($sformatf("%s_busy_c%0d", tag, c), busy, (c <= 12));
         if (c == 12) begin
            check({tag, "_res_data"}, res_data, exp_sum);
            check({tag, "_res_id"}, res_id, id);
            req = '0;
         end
      end
      $display("op %s id=%0d a=%0d b=%0d res=%0d", tag, id, a, b, res_data);
   endtask

   function automatic int rr_pick(input int last, input logic [NREQ-1:0] m);
      for (int k = 1; k <= NREQ; k++) begin
         if (m[(last + k) % NREQ]) return (last + k) % NREQ;
      end
      return -1;
   endfunction

   // mode 0: random traffic, mode 1: all four once, mode 2: requesters 0 and 2 held.
   task automatic run_engine(input int mode, input int ncyc);
      int g = 0, g_edge = 0, free_at = 0, m_last = NREQ - 1;
      bit m_busy = 0;
      logic [WIDTH-1:0] m_sum = '0;
      logic [NREQ-1:0] exp_ack;
      logic [NREQ-1:0] waiting = '0;
      int served[$];
      int ack_edge[$];
      for (int i = 0; i < NREQ; i++) new_ops(i);
      if (mode == 1) req = '1;
      else if (mode == 2) req = NREQ'(5);
      else req = '0;
      for (int e = 0; e < ncyc; e++) begin
         tick();
         if (!m_busy && e >= free_at && req != '0) begin
            g       = rr_pick(m_last, req);
            g_edge  = e;
            free_at = e + LATENCY + 3;
            m_busy  = 1;
            m_sum   = WIDTH'(req_a[g*WIDTH +: WIDTH] + req_b[g*WIDTH +: WIDTH]);
         end
         exp_ack = (m_busy && e == g_edge + LATENCY + 1) ? (NREQ'(1) << g) : '0;
         check("eng_ack", ack, exp_ack);
         check("eng_add_en", add_en, m_busy && e == g_edge);
         check("eng_busy", busy, m_busy);
         if (exp_ack != '0) begin
            check("eng_res_data", res_data, m_sum);
            check("eng_res_id", res_id, g);
            $display("mode %0d ack id=%0d cycle=%0d res=%0d", mode, g, e, res_data);
            served.push_back(g);
            ack_edge.push_back(e);
            m_last     = g;
            m_busy     = 0;
            waiting[g] = 1'b0;
            if (mode == 1 || (mode == 0 && $urandom_range(1) == 0)) req[g] = 1'b0;
            else new_ops(g);
         end
         if (mode == 0) begin
            for (int i = 0; i < NREQ; i++) begin
               if (m_busy && g == i && req[i]) begin
                  if ($urandom_range(7) == 0) begin
                     req[i]     = 1'b0;
                     waiting[i] = 1'b1;
                  end
                  if ($urandom_range(2) == 0) new_ops(i);
               end else if (!req[i] && !waiting[i] && $urandom_range(3) == 0) begin
                  new_ops(i);
                  req[i] = 1'b1;
               end
            end
         end
      end
      if (mode == 1) begin
         check("all4_count", served.size(), 4);
         for (int k = 0; k < served.size() && k < 4; k++)
            check($sformatf("all4_order_%0d", k), served[k], k);
         for (int k = 1; k < ack_edge.size(); k++)
            check($sformatf("all4_spacing_%0d", k), ack_edge[k] - ack_edge[k-1], 13);
      end
      if (mode == 2) begin
         check("fair_count_ge6", served.size() >= 6, 1);
         for (int k = 1; k < served.size(); k++)
            check($sformatf("fair_alternate_%0d", k), served[k] != served[k-1], 1);
      end
      req = '0;
   endtask

   typedef struct {
      int               id;
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] sum;
   } vec_t;

   vec_t tbl [6];

   initial begin
      tbl[0] = '{id: 0, a: 8'd100, b: 8'd27,  sum: 8'd127};
      tbl[1] = '{id: 1, a: 8'd200, b: 8'd100, sum: 8'd44};
      tbl[2] = '{id: 2, a: 8'd255, b: 8'd1,   sum: 8'd0};
      tbl[3] = '{id: 3, a: 8'd255, b: 8'd255, sum: 8'd254};
      tbl[4] = '{id: 2, a: 8'd0,   b: 8'd0,   sum: 8'd0};
      tbl[5] = '{id: 3, a: 8'd170, b: 8'd85,  sum: 8'd255};

      tick();
      do_reset();
      for (int v = 0; v < 6; v++) single_op($sformatf("vec%0d", v), tbl[v].id, tbl[v].a, tbl[v].b, tbl[v].sum);

      // Reset in the middle of the wait phase aborts; the held request is re-served.
      req_a[1*WIDTH +: WIDTH] = 8'd50;
      req_b[1*WIDTH +: WIDTH] = 8'd60;
      req = 4'b0010;
      for (int c = 1; c <= 6; c++) tick();
      rst = 1'b0;
      #1;
      check_quiet("midrst");
      tick();
      check("midrst_no_ack", ack, 0);
      tick();
      rst = 1'b1;
      single_op("midrst_reserve", 1, 8'd50, 8'd60, 8'd110);

      // Request dropped and operands changed after the grant.
      for (int i = 0; i < NREQ; i++) new_ops(i);
      req_a[3*WIDTH +: WIDTH] = 8'd10;
      req_b[3*WIDTH +: WIDTH] = 8'd20;
      req = 4'b1000;
      for (int c = 1; c <= 13; c++) begin
         tick();
         check($sformatf("drop_ack_c%0d", c), ack, (c == 12) ? 4'b1000 : 4'b0000);
         if (c <= 12) begin
            check($sformatf("drop_add_a_c%0d", c), add_a, 10);
            check($sformatf("drop_add_b_c%0d", c), add_b, 20);
         end
         if (c == 3) begin
            req = '0;
            req_a[3*WIDTH +: WIDTH] = 8'd99;
            req_b[3*WIDTH +: WIDTH] = 8'd1;
         end
         if (c == 12) begin
            check("drop_res_data", res_data, 30);
            check("drop_res_id", res_id, 3);
         end
      end
      $display("op drop id=3 res=%0d", res_data);
      for (int c = 0; c < 3; c++) begin
         tick();
         check("drop_idle_busy", busy, 0);
         check("drop_idle_add_en", add_en, 0);
      end

      do_reset();
      run_engine(1, 60);
      do_reset();
      run_engine(2, 13 * 8);
      do_reset();
      run_engine(0, 2000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/add_serial_sched.md
Name: add_serial_sched

Overview:
- Round-robin scheduler that shares one add_serial (8-bit bit-serial adder, IDLE/ADD/DONE sequencer) among NREQ requesters.
- Latches the winning requester's operands and fires a one-cycle start to the adder.
- Waits a fixed LATENCY, captures the sum, and returns it with a one-cycle ack to the owner.
- Sits between requester logic and the single adder instance. The adder is never driven by more than one requester.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, operand/result width; must match the adder.
- LATENCY, 10, cycles from the adder's start-pulse cycle to a valid adder output (minimum 9 for add_serial).
- IDW, 2, requester-id width, clog2(NREQ).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req  in  NREQ  per-requester request level; held until its ack.
- req_a  in  NREQ*WIDTH  operand A, requester i in slice [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand B, same packing.
- ack  out  NREQ  one-hot, one-cycle pulse: res_data is valid for that requester.
- res_data  out  WIDTH  sum, held until next RESP.
- res_id  out  IDW  id of the last served requester, held.
- busy  out  1  high in ISSUE/WAIT/RESP.
- add_en  out  1  start to adder, active-high.
- add_a  out  WIDTH  latched operand A to adder.
- add_b  out  WIDTH  latched operand B to adder.
- add_out  in  WIDTH  adder result.

Behaviour:
- Reset (rst low, async):
  - state=S_IDLE; ack, res_data, res_id, busy, add_en, add_a, add_b all 0.
  - cnt=0; last grant = NREQ-1, so requester 0 has first priority.
- Reset asserted mid-operation aborts it: no ack, operands discarded. Requesters must re-request.
- FSM states: S_IDLE, S_ISSUE, S_WAIT, S_RESP.
- S_IDLE:
  - If any req bit is high, grant the first set bit scanning (last+1) mod NREQ upward with wrap-around.
  - On the grant: latch id into gnt, latch that requester's req_a/req_b into add_a/add_b, go to S_ISSUE.
  - No req: stay in S_IDLE, all outputs quiet.
- S_ISSUE: add_en=1 for exactly this cycle, cnt<=0, go to S_WAIT.
- S_WAIT:
  - add_en=0; cnt increments each cycle.
  - In the cycle with cnt==LATENCY-1: res_data<=add_out, res_id<=gnt, go to S_RESP.
- S_RESP:
  - ack[gnt]=1 for this cycle only.
  - last<=gnt; go to S_IDLE.
- add_a/add_b are held stable from S_ISSUE through S_RESP and change only at the next grant.
- busy is registered-state decode; it is high exactly when state != S_IDLE.
- Timing: req high at edge k (state S_IDLE) gives:
  - add_en in cycle k+1;
  - ack in cycle k+2+LATENCY.
  - Back-to-back service period is LATENCY+3 cycles (13 at default).
- Arithmetic: result is (a+b) mod 2^WIDTH; carry-out is dropped and not reported.
- A req dropped after grant does not cancel the operation. ack is still pulsed to that id, and the requester ignores it.
- A req still high in the cycle after its ack is treated as a new request.
  - Round-robin still favours other pending requesters first.
- A requester with req held continuously is served at most once per full round when others are pending (no starvation).
- req_a/req_b changes after the grant edge have no effect on the operation in flight.
- gnt and cnt widths: IDW and clog2(LATENCY) bits. cnt never wraps because it is compared before overflow.

Test Plan:
- Single request: req=4'b0001, a0=8'd100, b0=8'd27 at edge 0 -> add_en high in cycle 1 only; ack=4'b0001 in cycle 12; res_data=127, res_id=0; busy low from cycle 13.
- Overflow: req[1], a1=8'd200, b1=8'd100 -> ack[1] with res_data=8'd44; no other ack bit ever set.
- All four requesting from reset, distinct operands -> grants in order 0,1,2,3; acks 13 cycles apart; each res_data matches its own operand sum.
- Fairness: req[0] and req[2] held continuously -> service alternates 0,2,0,2 for at least 6 operations; no two consecutive acks to the same id.
- Reset mid-S_WAIT (rst low in cycle 6 of an operation) -> all outputs 0 immediately, no ack; after rst release the still-high req is re-served with the correct sum.
- Req drop / operand change: req[3] deasserted and a3 changed in cycle 3 after grant -> ack[3] still pulses in cycle 12 with the originally latched sum; next arbitration ignores requester 3.
